// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV64IM ALU-class decode/issue stage with a single registered output slot
module alu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_sel,
  output logic [4:0]      rd,
  output logic            illegal
);

  // Major opcodes handled here; everything else is reported as illegal.
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  // ALU select codes understood by the downstream ALU.
  localparam logic [4:0] SEL_ADD   = 5'd0;
  localparam logic [4:0] SEL_SUB   = 5'd1;
  localparam logic [4:0] SEL_MUL   = 5'd2;
  localparam logic [4:0] SEL_DIV   = 5'd3;
  localparam logic [4:0] SEL_DIVU  = 5'd4;
  localparam logic [4:0] SEL_REM   = 5'd5;
  localparam logic [4:0] SEL_REMU  = 5'd6;
  localparam logic [4:0] SEL_AND   = 5'd7;
  localparam logic [4:0] SEL_OR    = 5'd8;
  localparam logic [4:0] SEL_XOR   = 5'd9;
  localparam logic [4:0] SEL_LTU   = 5'd11;
  localparam logic [4:0] SEL_LT    = 5'd15;
  localparam logic [4:0] SEL_SLL   = 5'd16;
  localparam logic [4:0] SEL_SRA   = 5'd17;
  localparam logic [4:0] SEL_SRL   = 5'd18;
  localparam logic [4:0] SEL_ADDW  = 5'd19;
  localparam logic [4:0] SEL_SUBW  = 5'd20;
  localparam logic [4:0] SEL_SLLW  = 5'd21;
  localparam logic [4:0] SEL_SRAW  = 5'd22;
  localparam logic [4:0] SEL_SRLW  = 5'd23;
  localparam logic [4:0] SEL_MULW  = 5'd24;
  localparam logic [4:0] SEL_DIVW  = 5'd25;
  localparam logic [4:0] SEL_DIVUW = 5'd26;
  localparam logic [4:0] SEL_REMW  = 5'd27;
  localparam logic [4:0] SEL_REMUW = 5'd28;

  typedef enum logic [1:0] {
    A_RS1,
    A_ZERO,
    A_PC
  } a_src_e;

  typedef enum logic [2:0] {
    B_RS2,
    B_IMM_I,
    B_SHAMT6,
    B_SHAMT5,
    B_IMM_U
  } b_src_e;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];

  // Immediate forms
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};

  // Decode results
  logic            dec_legal;
  logic [4:0]      dec_sel_raw;
  a_src_e          a_src;
  b_src_e          b_src;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_raw;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_sel;

  // Classify the instruction: legality, ALU select and operand sources.
  always_comb begin
    dec_legal   = 1'b0;
    dec_sel_raw = SEL_ADD;
    a_src       = A_RS1;
    b_src       = B_RS2;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          7'b0000000: begin
            dec_legal = 1'b1;
            case (funct3)
              3'd0:    dec_sel_raw = SEL_ADD;
              3'd1:    dec_sel_raw = SEL_SLL;
              3'd2:    dec_sel_raw = SEL_LT;
              3'd3:    dec_sel_raw = SEL_LTU;
              3'd4:    dec_sel_raw = SEL_XOR;
              3'd5:    dec_sel_raw = SEL_SRL;
              3'd6:    dec_sel_raw = SEL_OR;
              default: dec_sel_raw = SEL_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'd0: begin dec_legal = 1'b1; dec_sel_raw = SEL_SUB; end
              3'd5: begin dec_legal = 1'b1; dec_sel_raw = SEL_SRA; end
              default: ;
            endcase
          end
          7'b0000001: begin
            // mulh/mulhsu/mulhu (funct3 1..3) are not supported by this ALU
            case (funct3)
              3'd0: begin dec_legal = 1'b1; dec_sel_raw = SEL_MUL;  end
              3'd4: begin dec_legal = 1'b1; dec_sel_raw = SEL_DIV;  end
              3'd5: begin dec_legal = 1'b1; dec_sel_raw = SEL_DIVU; end
              3'd6: begin dec_legal = 1'b1; dec_sel_raw = SEL_REM;  end
              3'd7: begin dec_legal = 1'b1; dec_sel_raw = SEL_REMU; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        b_src = B_IMM_I;
        case (funct3)
          3'd0: begin dec_legal = 1'b1; dec_sel_raw = SEL_ADD; end
          3'd2: begin dec_legal = 1'b1; dec_sel_raw = SEL_LT;  end
          3'd3: begin dec_legal = 1'b1; dec_sel_raw = SEL_LTU; end
          3'd4: begin dec_legal = 1'b1; dec_sel_raw = SEL_XOR; end
          3'd6: begin dec_legal = 1'b1; dec_sel_raw = SEL_OR;  end
          3'd7: begin dec_legal = 1'b1; dec_sel_raw = SEL_AND; end
          3'd1: begin
            b_src = B_SHAMT6;
            if (funct6 == 6'b000000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SLL;
            end
          end
          default: begin
            b_src = B_SHAMT6;
            if (funct6 == 6'b000000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SRL;
            end else if (funct6 == 6'b010000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SRA;
            end
          end
        endcase
      end
      OPC_OP_32: begin
        case ({funct7, funct3})
          {7'b0000000, 3'd0}: begin dec_legal = 1'b1; dec_sel_raw = SEL_ADDW;  end
          {7'b0000000, 3'd1}: begin dec_legal = 1'b1; dec_sel_raw = SEL_SLLW;  end
          {7'b0000000, 3'd5}: begin dec_legal = 1'b1; dec_sel_raw = SEL_SRLW;  end
          {7'b0100000, 3'd0}: begin dec_legal = 1'b1; dec_sel_raw = SEL_SUBW;  end
          {7'b0100000, 3'd5}: begin dec_legal = 1'b1; dec_sel_raw = SEL_SRAW;  end
          {7'b0000001, 3'd0}: begin dec_legal = 1'b1; dec_sel_raw = SEL_MULW;  end
          {7'b0000001, 3'd4}: begin dec_legal = 1'b1; dec_sel_raw = SEL_DIVW;  end
          {7'b0000001, 3'd5}: begin dec_legal = 1'b1; dec_sel_raw = SEL_DIVUW; end
          {7'b0000001, 3'd6}: begin dec_legal = 1'b1; dec_sel_raw = SEL_REMW;  end
          {7'b0000001, 3'd7}: begin dec_legal = 1'b1; dec_sel_raw = SEL_REMUW; end
          default: ;
        endcase
      end
      OPC_OP_IMM_32: begin
        // Word shifts only have a 5-bit shamt, so inst[25] must be clear
        case (funct3)
          3'd0: begin
            b_src       = B_IMM_I;
            dec_legal   = 1'b1;
            dec_sel_raw = SEL_ADDW;
          end
          3'd1: begin
            b_src = B_SHAMT5;
            if (funct7 == 7'b0000000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SLLW;
            end
          end
          3'd5: begin
            b_src = B_SHAMT5;
            if (funct7 == 7'b0000000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SRLW;
            end else if (funct7 == 7'b0100000) begin
              dec_legal   = 1'b1;
              dec_sel_raw = SEL_SRAW;
            end
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        dec_legal   = 1'b1;
        dec_sel_raw = SEL_ADD;
        a_src       = A_ZERO;
        b_src       = B_IMM_U;
      end
      OPC_AUIPC: begin
        dec_legal   = 1'b1;
        dec_sel_raw = SEL_ADD;
        a_src       = A_PC;
        b_src       = B_IMM_U;
      end
      default: ;
    endcase
  end

  // Operand muxing; illegal instructions present zeroed operands and select.
  always_comb begin
    a_raw = rs1_val;
    b_raw = rs2_val;
    case (a_src)
      A_ZERO:  a_raw = '0;
      A_PC:    a_raw = pc;
      default: a_raw = rs1_val;
    endcase
    case (b_src)
      B_IMM_I:  b_raw = imm_i;
      B_SHAMT6: b_raw = shamt6;
      B_SHAMT5: b_raw = shamt5;
      B_IMM_U:  b_raw = imm_u;
      default:  b_raw = rs2_val;
    endcase
    dec_a   = dec_legal ? a_raw : '0;
    dec_b   = dec_legal ? b_raw : '0;
    dec_sel = dec_legal ? dec_sel_raw : 5'd0;
  end

  // Output slot registers
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [4:0]      alu_sel_q, alu_sel_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;
  logic            load;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Next-state for the slot: load on accept, drain on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rd_d        = rd_q;
    illegal_d   = illegal_q;
    if (load) begin
      out_valid_d = 1'b1;
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      alu_sel_d   = dec_sel;
      rd_d        = inst[11:7];
      illegal_d   = !dec_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Slot state register; reset discards any held op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 5'd0;
      rd_q        <= 5'd0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with table-driven decode reference
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_sel;
  logic [4:0]  rd;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_issue #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  // Instruction table: opcode, funct3 (-1 any), top-field width (0 none, 6 = inst[31:26],
  // 7 = inst[31:25]), top value, select, A kind (0 rs1, 1 zero, 2 pc),
  // B kind (0 rs2, 1 simm12, 2 shamt6, 3 shamt5, 4 upper imm)
  typedef struct {
    logic [6:0] opc;
    int f3;
    int tw;
    int top;
    int sel;
    int ak;
    int bk;
  } ent_t;

  ent_t tbl[$];

  task automatic add_ent(input logic [6:0] opc, input int f3, input int tw, input int top,
                         input int sel, input int ak, input int bk);
    ent_t e;
    e.opc = opc; e.f3 = f3; e.tw = tw; e.top = top; e.sel = sel; e.ak = ak; e.bk = bk;
    tbl.push_back(e);
  endtask

  task automatic build_table();
    // OP
    add_ent(7'h33, 0, 7, 'h00, 0, 0, 0);  add_ent(7'h33, 1, 7, 'h00, 16, 0, 0);
    add_ent(7'h33, 2, 7, 'h00, 15, 0, 0); add_ent(7'h33, 3, 7, 'h00, 11, 0, 0);
    add_ent(7'h33, 4, 7, 'h00, 9, 0, 0);  add_ent(7'h33, 5, 7, 'h00, 18, 0, 0);
    add_ent(7'h33, 6, 7, 'h00, 8, 0, 0);  add_ent(7'h33, 7, 7, 'h00, 7, 0, 0);
    add_ent(7'h33, 0, 7, 'h20, 1, 0, 0);  add_ent(7'h33, 5, 7, 'h20, 17, 0, 0);
    add_ent(7'h33, 0, 7, 'h01, 2, 0, 0);  add_ent(7'h33, 4, 7, 'h01, 3, 0, 0);
    add_ent(7'h33, 5, 7, 'h01, 4, 0, 0);  add_ent(7'h33, 6, 7, 'h01, 5, 0, 0);
    add_ent(7'h33, 7, 7, 'h01, 6, 0, 0);
    // OP-IMM
    add_ent(7'h13, 0, 0, 0, 0, 0, 1);  add_ent(7'h13, 2, 0, 0, 15, 0, 1);
    add_ent(7'h13, 3, 0, 0, 11, 0, 1); add_ent(7'h13, 4, 0, 0, 9, 0, 1);
    add_ent(7'h13, 6, 0, 0, 8, 0, 1);  add_ent(7'h13, 7, 0, 0, 7, 0, 1);
    add_ent(7'h13, 1, 6, 'h00, 16, 0, 2);
    add_ent(7'h13, 5, 6, 'h00, 18, 0, 2);
    add_ent(7'h13, 5, 6, 'h10, 17, 0, 2);
    // OP-32
    add_ent(7'h3B, 0, 7, 'h00, 19, 0, 0); add_ent(7'h3B, 1, 7, 'h00, 21, 0, 0);
    add_ent(7'h3B, 5, 7, 'h00, 23, 0, 0); add_ent(7'h3B, 0, 7, 'h20, 20, 0, 0);
    add_ent(7'h3B, 5, 7, 'h20, 22, 0, 0); add_ent(7'h3B, 0, 7, 'h01, 24, 0, 0);
    add_ent(7'h3B, 4, 7, 'h01, 25, 0, 0); add_ent(7'h3B, 5, 7, 'h01, 26, 0, 0);
    add_ent(7'h3B, 6, 7, 'h01, 27, 0, 0); add_ent(7'h3B, 7, 7, 'h01, 28, 0, 0);
    // OP-IMM-32
    add_ent(7'h1B, 0, 0, 0, 19, 0, 1);
    add_ent(7'h1B, 1, 7, 'h00, 21, 0, 3);
    add_ent(7'h1B, 5, 7, 'h00, 23, 0, 3);
    add_ent(7'h1B, 5, 7, 'h20, 22, 0, 3);
    // LUI / AUIPC
    add_ent(7'h37, -1, 0, 0, 0, 1, 4);
    add_ent(7'h17, -1, 0, 0, 0, 2, 4);
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                 input logic [63:0] r1, input logic [63:0] r2);
    exp_t e;
    bit   hit;
    e.a = '0; e.b = '0; e.sel = '0; e.rd = i[11:7]; e.ill = 1'b1;
    hit = 0;
    foreach (tbl[k]) begin
      if (!hit && i[6:0] == tbl[k].opc &&
          (tbl[k].f3 < 0 || int'(i[14:12]) == tbl[k].f3) &&
          (tbl[k].tw == 0 ||
           (tbl[k].tw == 6 && int'(i[31:26]) == tbl[k].top) ||
           (tbl[k].tw == 7 && int'(i[31:25]) == tbl[k].top))) begin
        hit   = 1;
        e.ill = 1'b0;
        e.sel = 5'(tbl[k].sel);
        case (tbl[k].ak)
          1:       e.a = 64'd0;
          2:       e.a = p;
          default: e.a = r1;
        endcase
        case (tbl[k].bk)
          1:       e.b = longint'($signed(i[31:20]));
          2:       e.b = 64'(i[25:20]);
          3:       e.b = 64'(i[24:20]);
          4:       e.b = longint'($signed({i[31:12], 12'h000}));
          default: e.b = r2;
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    ent_t        e;
    int          mode;
    w    = $urandom;
    mode = $urandom_range(0, 3);
    if (mode == 1) begin
      case ($urandom_range(0, 5))
        0:       w[6:0] = 7'h33;
        1:       w[6:0] = 7'h13;
        2:       w[6:0] = 7'h3B;
        3:       w[6:0] = 7'h1B;
        4:       w[6:0] = 7'h37;
        default: w[6:0] = 7'h17;
      endcase
    end else if (mode >= 2) begin
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      w[6:0] = e.opc;
      if (e.f3 >= 0) w[14:12] = 3'(e.f3);
      if (e.tw == 6) w[31:26] = 6'(e.top);
      if (e.tw == 7) w[31:25] = 7'(e.top);
    end
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r1, input logic [63:0] r2);
    in_valid = v; inst = i; pc = p; rs1_val = r1; rs2_val = r2;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_sel !== 5'd0 ||
        rd !== 5'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h sel=%0d rd=%0d ill=%b, want all zero",
               out_valid, alu_a, alu_b, alu_sel, rd, illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_decode_directed();
    logic [63:0] r;
    out_ready = 1'b1;
    // add x3,x1,x2
    drive(1'b1, 32'h002081B3, 64'h0, 64'd5, 64'd7);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || alu_a !== 64'd5 || alu_b !== 64'd7 || alu_sel !== 5'd0 ||
        rd !== 5'd3 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL add: got v=%b a=%h b=%h sel=%0d rd=%0d ill=%b, want 1 5 7 0 3 0",
               out_valid, alu_a, alu_b, alu_sel, rd, illegal);
    end
    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 64'h0, 64'd0, 64'h1234);
    @(posedge clk); #1;
    checks++;
    if (alu_a !== 64'd0 || alu_b !== 64'hFFFF_FFFF_FFFF_FFFF || alu_sel !== 5'd0 ||
        rd !== 5'd1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi_neg: got a=%h b=%h sel=%0d rd=%0d ill=%b, want 0 ffffffffffffffff 0 1 0",
               alu_a, alu_b, alu_sel, rd, illegal);
    end
    // srai x5,x6,63
    r = {$urandom, $urandom};
    drive(1'b1, 32'h43F35293, 64'h0, r, 64'h99);
    @(posedge clk); #1;
    checks++;
    if (alu_a !== r || alu_b !== 64'd63 || alu_sel !== 5'd17 || rd !== 5'd5 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL srai: got a=%h b=%h sel=%0d rd=%0d ill=%b, want %h 63 17 5 0",
               alu_a, alu_b, alu_sel, rd, illegal, r);
    end
    // slliw with inst[25]=1 is illegal
    drive(1'b1, 32'h0200909B, 64'h40, 64'hABCD, 64'h55);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_sel !== 5'd0 || alu_a !== 64'd0 ||
        alu_b !== 64'd0 || rd !== 5'd1) begin
      errors++;
      $display("FAIL slliw_bad: got v=%b ill=%b sel=%0d a=%h b=%h rd=%0d, want 1 1 0 0 0 1",
               out_valid, illegal, alu_sel, alu_a, alu_b, rd);
    end
    // lui x7,0x80000: upper immediate sign-extends into bits 63:32
    drive(1'b1, 32'h800003B7, 64'h0, 64'h77, 64'h88);
    @(posedge clk); #1;
    checks++;
    if (alu_a !== 64'd0 || alu_b !== 64'hFFFF_FFFF_8000_0000 || alu_sel !== 5'd0 ||
        rd !== 5'd7 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL lui: got a=%h b=%h sel=%0d rd=%0d ill=%b, want 0 ffffffff80000000 0 7 0",
               alu_a, alu_b, alu_sel, rd, illegal);
    end
    // auipc x2,0x12345
    drive(1'b1, 32'h12345117, 64'h1000, 64'h77, 64'h88);
    @(posedge clk); #1;
    checks++;
    if (alu_a !== 64'h1000 || alu_b !== 64'h1234_5000 || alu_sel !== 5'd0 ||
        rd !== 5'd2 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL auipc: got a=%h b=%h sel=%0d rd=%0d ill=%b, want 1000 12345000 0 2 0",
               alu_a, alu_b, alu_sel, rd, illegal);
    end
    // consume with nothing new: valid drops, data holds
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 64'h1000 || alu_b !== 64'h1234_5000) begin
      errors++;
      $display("FAIL drain_hold: got v=%b a=%h b=%h, want 0 1000 12345000",
               out_valid, alu_a, alu_b);
    end
  endtask

  task automatic test_backpressure();
    exp_t e1, e2;
    e1 = model(32'h002081B3, 64'h0, 64'd11, 64'd22);
    e2 = model(32'h40628233, 64'h0, 64'd100, 64'd30);
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h0, 64'd11, 64'd22);
    @(posedge clk); #1;
    drive(1'b1, 32'h40628233, 64'h0, 64'd100, 64'd30);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {alu_a, alu_b, alu_sel, rd, illegal} !== {e1.a, e1.b, e1.sel, e1.rd, e1.ill}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b a=%h b=%h sel=%0d rd=%0d, want 0 1 %h %h %0d %0d",
                 c, in_ready, out_valid, alu_a, alu_b, alu_sel, rd, e1.a, e1.b, e1.sel, e1.rd);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_follows_out_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    checks++;
    if (out_valid !== 1'b1 ||
        {alu_a, alu_b, alu_sel, rd, illegal} !== {e2.a, e2.b, e2.sel, e2.rd, e2.ill}) begin
      errors++;
      $display("FAIL second_op: got v=%b a=%h b=%h sel=%0d rd=%0d, want 1 %h %h %0d %0d",
               out_valid, alu_a, alu_b, alu_sel, rd, e2.a, e2.b, e2.sel, e2.rd);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL second_op_once: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        ex[4];
    logic [31:0] iw[4];
    logic [63:0] r1[4];
    logic [63:0] r2[4];
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iw[k] = gen_inst();
      r1[k] = {$urandom, $urandom};
      r2[k] = {$urandom, $urandom};
      ex[k] = model(iw[k], 64'h8000, r1[k], r2[k]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, iw[k], 64'h8000, r1[k], r2[k]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 ||
          {alu_a, alu_b, alu_sel, rd, illegal} !== {ex[k].a, ex[k].b, ex[k].sel, ex[k].rd, ex[k].ill}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b a=%h b=%h sel=%0d rd=%0d ill=%b, want 1 %h %h %0d %0d %b",
                 k, out_valid, alu_a, alu_b, alu_sel, rd, illegal,
                 ex[k].a, ex[k].b, ex[k].sel, ex[k].rd, ex[k].ill);
      end
    end
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    exp_t        sb[$];
    exp_t        e;
    bit          fi, fo;
    logic [31:0] iw;
    logic [63:0] p, r1, r2;
    for (int c = 0; c < 600; c++) begin
      iw = gen_inst();
      p  = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), iw, p, r1, r2);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (out_valid !== (sb.size() != 0) || in_ready !== (sb.size() == 0 || out_ready)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: got v=%b rdy=%b, want v=%b rdy=%b",
                 c, out_valid, in_ready, (sb.size() != 0), (sb.size() == 0 || out_ready));
      end
      if (sb.size() != 0) begin
        e = sb[0];
        checks++;
        if ({alu_a, alu_b, alu_sel, rd, illegal} !== {e.a, e.b, e.sel, e.rd, e.ill}) begin
          errors++;
          $display("FAIL rand_data[%0d]: got a=%h b=%h sel=%0d rd=%0d ill=%b, want %h %h %0d %0d %b",
                   c, alu_a, alu_b, alu_sel, rd, illegal, e.a, e.b, e.sel, e.rd, e.ill);
        end
      end
      fo = (sb.size() != 0) && out_ready;
      fi = in_valid && (sb.size() == 0 || out_ready);
      if (fo) void'(sb.pop_front());
      if (fi) sb.push_back(model(iw, p, r1, r2));
      @(posedge clk); #1;
    end
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    out_ready = 1'b1;
    for (int c = 0; c < 4 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
      void'(sb.pop_front());
    end
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got v=%b pending=%0d, want 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h0, 64'd9, 64'd8);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: out_valid got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_sel !== 5'd0 ||
        rd !== 5'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: got v=%b a=%h b=%h sel=%0d rd=%0d ill=%b, want all zero",
               out_valid, alu_a, alu_b, alu_sel, rd, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: got rdy=%b v=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
    build_table();
    test_reset();
    test_decode_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that sits in front of the combinational 64-bit ALU and drives its operand/select interface.
- Accepts one RV64IM integer instruction per handshake, together with its PC and register-file operands.
- Decodes the instruction into ALU operands A/B and the 5-bit ALU select code.
- Registers the result in a single output stage with a valid/ready handshake. Loads, stores, branches and jumps are handled elsewhere; this block flags them as illegal.

Parameters:
- XLEN, 64, datapath width of pc, operands and outputs.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block can accept this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  instruction address.
- rs1_val  in  XLEN  value of register rs1.
- rs2_val  in  XLEN  value of register rs2.
- out_valid  out  1  issued op valid.
- out_ready  in  1  ALU/writeback consumes the op.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_sel  out  5  ALU select code.
- rd  out  5  destination register.
- illegal  out  1  instruction is not an ALU-class instruction.

Behaviour:
- Reset (rst_n=0, asynchronous, allowed mid-transfer): out_valid=0 immediately; alu_a=0, alu_b=0, alu_sel=0, rd=0, illegal=0. The held op is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer-in happens when in_valid && in_ready. Transfer-out happens when out_valid && out_ready.
  - On transfer-in, the decoded fields load into the output register. out_valid=1 on the next cycle, so latency is 1 cycle.
  - Simultaneous transfer-in and transfer-out: new op replaces old and out_valid stays 1. Throughput is 1 op/cycle.
  - Transfer-out with no transfer-in: out_valid goes to 0 and the data registers hold their last values.
  - While out_valid && !out_ready, all outputs are held stable.
- Select encoding (fixed):
  - 0 add, 1 sub, 2 mul, 3 div, 4 divu, 5 rem, 6 remu.
  - 7 and, 8 or, 9 xor.
  - 10 geu, 11 ltu, 12 eq, 13 ne, 14 ge, 15 lt.
  - 16 sll, 17 sra, 18 srl.
  - 19 addw, 20 subw, 21 sllw, 22 sraw, 23 srlw.
  - 24 mulw, 25 divw, 26 divuw, 27 remw, 28 remuw.
- Decode by opcode inst[6:0]. In every case rd = inst[11:7].
- OP (0110011):
  - A = rs1_val, B = rs2_val.
  - funct7=0000000: f3 0 add, 1 sll, 2 lt (slt), 3 ltu (sltu), 4 xor, 5 srl, 6 or, 7 and.
  - funct7=0100000: f3 0 sub, 5 sra.
  - funct7=0000001: f3 0 mul, 4 div, 5 divu, 6 rem, 7 remu. f3 1–3 (mulh*) are illegal.
- OP-IMM (0010011):
  - A = rs1_val, B = sign-extended inst[31:20].
  - f3 0 add, 2 lt, 3 ltu, 4 xor, 6 or, 7 and.
  - Shifts: f3 1 sll, f3 5 with inst[31:26]=000000 srl or 010000 sra. B = zero-extended inst[25:20]. Any other inst[31:26] is illegal.
- OP-32 (0111011):
  - A = rs1_val, B = rs2_val.
  - f7 0000000: f3 0 addw, 1 sllw, 5 srlw.
  - f7 0100000: f3 0 subw, 5 sraw.
  - f7 0000001: f3 0 mulw, 4 divw, 5 divuw, 6 remw, 7 remuw.
- OP-IMM-32 (0011011):
  - f3 0 addw with sign-extended imm.
  - f3 1 sllw, and f3 5 srlw/sraw selected by inst[31:26] as for OP-IMM. B = zero-extended inst[24:20].
  - inst[25]=1 on a shift is illegal.
- LUI (0110111): A = 0, B = sign-extended {inst[31:12], 12'b0}, sel add.
- AUIPC (0010111): A = pc, B = same immediate as LUI, sel add.
- Any other opcode or funct combination: illegal=1, alu_a=0, alu_b=0, alu_sel=0, rd=inst[11:7]. The handshake completes normally.
- rd=0 is passed through unchanged; suppressing the write is the writeback stage's job.

Test Plan:
- Reset, then inst=0x002081B3 (add x3,x1,x2), rs1_val=5, rs2_val=7, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_sel=0, rd=3, illegal=0.
- inst=0xFFF00093 (addi x1,x0,-1), rs1_val=0 -> alu_b=0xFFFF_FFFF_FFFF_FFFF, alu_sel=0, rd=1.
- inst=0x43F35293 (srai x5,x6,63) -> alu_sel=17, alu_b=63, rd=5. inst=0x0200909B (slliw, inst[25]=1) -> illegal=1, alu_sel=0, alu_a=0, alu_b=0.
- out_ready=0 with an op held while in_valid=1 with a new op -> in_ready=0, outputs unchanged for 3 cycles. Raise out_ready -> same cycle in_ready=1, next cycle the new op appears. Both ops observed exactly once.
- Back-to-back stream of 4 ops with out_ready=1 -> out_valid stays 1 for 4 consecutive cycles, in order, no bubbles.
- Assert rst_n=0 asynchronously while out_valid=1 -> out_valid=0 before the next clk edge, all outputs 0. Deassert -> in_ready=1.
